chip_set: RTL and testbench

CHIP_SET -- requirements
Module: chip_set

---
 rtl/chipset_pkg.sv | 26 ++
 rtl/chipset_range_cmp.sv | 36 +++
 rtl/chip_set.sv | 133 +++++++++++++
 tb/tb_chip_set.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/chipset_pkg.sv
// -----------------------------------------------------------------------------
// chipset_pkg
// Shared definitions for the chip_set address decoder.
//   addr_t           : 19-bit CPU byte address type
//   *_DEF constants  : default base/limit of the two memory regions
//   MSEL_MEM1/2      : encoding of the read-data mux select (memSel)
// -----------------------------------------------------------------------------
package chipset_pkg;

  localparam int ADDR_W = 19;

  typedef logic [ADDR_W-1:0] addr_t;

  // Default memory map: a small memory 1 at the bottom, memory 2 directly above.
  localparam addr_t MEM1_BASE_DEF  = 19'h00000;
  localparam addr_t MEM1_LIMIT_DEF = 19'h0003F;
  localparam addr_t MEM2_BASE_DEF  = 19'h00040;
  localparam addr_t MEM2_LIMIT_DEF = 19'h1FFFF;

  // Read-data mux select encoding.
  localparam logic MSEL_MEM1 = 1'b0;
  localparam logic MSEL_MEM2 = 1'b1;

  localparam int NUM_REGIONS = 2;

endpackage : chipset_pkg

// File: rtl/chipset_range_cmp.sv
// -----------------------------------------------------------------------------
// chipset_range_cmp
// Purely combinational region matcher: flags BASE <= address <= LIMIT
// (unsigned) and produces the offset of the address inside the region.
// Ports:
//   address : input  addr_t, CPU byte address
//   hit     : output, 1 when the address falls inside [BASE, LIMIT]
//   offset  : output addr_t, address - BASE (only meaningful when hit=1)
// -----------------------------------------------------------------------------
module chipset_range_cmp
  import chipset_pkg::*;
#(
  parameter addr_t BASE  = '0,
  parameter addr_t LIMIT = '1
) (
  input  addr_t address,
  output logic  hit,
  output addr_t offset
);

  // One extra bit on the subtraction: its MSB is the borrow, i.e. address < BASE.
  // This shares the subtractor between the lower-bound test and the offset,
  // and avoids an always-true compare when BASE is zero.
  logic [ADDR_W:0] lo_diff;
  logic            below_base;
  logic            above_limit;

  assign lo_diff     = {1'b0, address} - {1'b0, BASE};
  assign below_base  = lo_diff[ADDR_W];
  // Widened compare keeps the result non-constant even for LIMIT = all ones.
  assign above_limit = ({1'b0, address} > {1'b0, LIMIT});

  assign hit    = ~below_base & ~above_limit;
  assign offset = lo_diff[ADDR_W-1:0];

endmodule : chipset_range_cmp

// File: rtl/chip_set.sv
// -----------------------------------------------------------------------------
// chip_set
// Address decoder for a CPU with two memories.
// Ports:
//   clk        : input,  single clock
//   rst        : input,  synchronous active-high reset
//   address    : input,  19-bit CPU byte address
//   memWrite   : input,  CPU write strobe for this cycle
//   memRead    : input,  CPU read strobe for this cycle
//   en1        : output, memory 1 write enable (combinational)
//   en2        : output, memory 2 write enable (combinational)
//   memSel     : output, read-data mux select, registered (0 = mem1, 1 = mem2)
//   localAddr  : output, offset inside the selected memory (combinational)
//   decErr     : output, one-cycle pulse after an unmapped access
//   errSticky  : output, set by any unmapped access, cleared only by rst
// Configuration:
//   CHIPSET_DECERR_EN : when defined, decErr/errSticky are real registers;
//                       otherwise both are tied to 0 and no error state exists.
// -----------------------------------------------------------------------------
module chip_set
  import chipset_pkg::*;
#(
  parameter addr_t MEM1_BASE  = MEM1_BASE_DEF,
  parameter addr_t MEM1_LIMIT = MEM1_LIMIT_DEF,
  parameter addr_t MEM2_BASE  = MEM2_BASE_DEF,
  parameter addr_t MEM2_LIMIT = MEM2_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic              memWrite,
  input  logic              memRead,
  output logic              en1,
  output logic              en2,
  output logic              memSel,
  output logic [ADDR_W-1:0] localAddr,
  output logic              decErr,
  output logic              errSticky
);

  // ---------------------------------------------------------------------------
  // Region matching: one comparator per region, index 0 = memory 1.
  // ---------------------------------------------------------------------------
  logic [NUM_REGIONS-1:0] hit_raw;
  addr_t                  offset_raw [NUM_REGIONS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGIONS; gi++) begin : g_region
      chipset_range_cmp #(
        .BASE  ((gi == 0) ? MEM1_BASE  : MEM2_BASE),
        .LIMIT ((gi == 0) ? MEM1_LIMIT : MEM2_LIMIT)
      ) u_cmp (
        .address (address),
        .hit     (hit_raw[gi]),
        .offset  (offset_raw[gi])
      );
    end
  endgenerate

  logic hit1;
  logic hit2;
  logic access;

  // Memory 1 has priority where the two regions overlap.
  assign hit1   = hit_raw[0];
  assign hit2   = hit_raw[1] & ~hit1;
  assign access = memRead | memWrite;

  // ---------------------------------------------------------------------------
  // Write enables: same-cycle, and masked by reset so an access caught by a
  // reset never produces an enable pulse. A combined read+write counts as a
  // write here. hit1/hit2 are exclusive, so the enables are too.
  // ---------------------------------------------------------------------------
  assign en1 = memWrite & hit1 & ~rst;
  assign en2 = memWrite & hit2 & ~rst;

  // ---------------------------------------------------------------------------
  // Local address: offset into whichever region matched, zero otherwise.
  // ---------------------------------------------------------------------------
  always_comb begin
    localAddr = '0;
    if (hit1) begin
      localAddr = offset_raw[0];
    end else if (hit2) begin
      localAddr = offset_raw[1];
    end
  end

  // ---------------------------------------------------------------------------
  // Read-data select: captured on every access so it lines up with the data
  // of a synchronous RAM one cycle later; held across idle cycles.
  // ---------------------------------------------------------------------------
  logic mem_sel_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_sel_reg <= MSEL_MEM1;
    end else if (access) begin
      mem_sel_reg <= hit2 ? MSEL_MEM2 : MSEL_MEM1;
    end
  end

  assign memSel = mem_sel_reg;

  // ---------------------------------------------------------------------------
  // Decode-error reporting.
  // ---------------------------------------------------------------------------
`ifdef CHIPSET_DECERR_EN
  logic unmapped;
  logic dec_err_reg;
  logic err_sticky_reg;

  assign unmapped = access & ~hit1 & ~hit2;

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_err_reg    <= 1'b0;
      err_sticky_reg <= 1'b0;
    end else begin
      dec_err_reg    <= unmapped;
      err_sticky_reg <= err_sticky_reg | unmapped;
    end
  end

  assign decErr    = dec_err_reg;
  assign errSticky = err_sticky_reg;
`else
  assign decErr    = 1'b0;
  assign errSticky = 1'b0;
`endif

endmodule : chip_set

// File: tb/tb_chip_set.sv
// -----------------------------------------------------------------------------
// tb_chip_set
// Directed, table-driven bench for chip_set with the default memory map
// (mem1 = 0x00000..0x0003F, mem2 = 0x00040..0x1FFFF). Each table row drives
// one cycle of inputs, checks the combinational outputs mid-cycle, then checks
// the registered outputs just after the following clock edge.
// Error outputs are expected to stay 0 unless CHIPSET_DECERR_EN is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_chip_set;

`ifdef CHIPSET_DECERR_EN
  localparam bit DECERR_ON = 1'b1;
`else
  localparam bit DECERR_ON = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [18:0] address;
  logic        memWrite;
  logic        memRead;
  logic        en1;
  logic        en2;
  logic        memSel;
  logic [18:0] localAddr;
  logic        decErr;
  logic        errSticky;

  int checks = 0;
  int errors = 0;

  chip_set dut (
    .clk       (clk),
    .rst       (rst),
    .address   (address),
    .memWrite  (memWrite),
    .memRead   (memRead),
    .en1       (en1),
    .en2       (en2),
    .memSel    (memSel),
    .localAddr (localAddr),
    .decErr    (decErr),
    .errSticky (errSticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [18:0] addr;
    logic        wr;
    logic        rd;
    logic        exp_en1;
    logic        exp_en2;
    logic [18:0] exp_la;
    logic        exp_sel;     // memSel after the edge
    logic        exp_dec;     // decErr after the edge (when error logic present)
    logic        exp_sticky;  // errSticky after the edge (when error logic present)
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic [18:0] a, input logic w, input logic rd);
    rst      = r;
    address  = a;
    memWrite = w;
    memRead  = rd;
  endtask

  // Wait for the next rising edge, then settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // addr, wr, rd, en1, en2, localAddr, sel, dec, sticky
    vecs[0]  = '{19'd50,     1'b1, 1'b0, 1'b1, 1'b0, 19'd50,     1'b0, 1'b0, 1'b0};
    vecs[1]  = '{19'd50,     1'b0, 1'b0, 1'b0, 1'b0, 19'd50,     1'b0, 1'b0, 1'b0};
    vecs[2]  = '{19'd77,     1'b0, 1'b0, 1'b0, 1'b0, 19'd13,     1'b0, 1'b0, 1'b0};
    vecs[3]  = '{19'd77,     1'b1, 1'b0, 1'b0, 1'b1, 19'd13,     1'b1, 1'b0, 1'b0};
    vecs[4]  = '{19'd63,     1'b1, 1'b0, 1'b1, 1'b0, 19'd63,     1'b0, 1'b0, 1'b0};
    vecs[5]  = '{19'd64,     1'b1, 1'b0, 1'b0, 1'b1, 19'd0,      1'b1, 1'b0, 1'b0};
    vecs[6]  = '{19'h1FFFF,  1'b1, 1'b0, 1'b0, 1'b1, 19'h1FFBF,  1'b1, 1'b0, 1'b0};
    vecs[7]  = '{19'h20000,  1'b1, 1'b0, 1'b0, 1'b0, 19'd0,      1'b0, 1'b1, 1'b1};
    vecs[8]  = '{19'd0,      1'b1, 1'b0, 1'b1, 1'b0, 19'd0,      1'b0, 1'b0, 1'b1};
    vecs[9]  = '{19'd50,     1'b1, 1'b1, 1'b1, 1'b0, 19'd50,     1'b0, 1'b0, 1'b1};
    vecs[10] = '{19'h7FFFF,  1'b0, 1'b1, 1'b0, 1'b0, 19'd0,      1'b0, 1'b1, 1'b1};
    vecs[11] = '{19'd77,     1'b0, 1'b1, 1'b0, 1'b0, 19'd13,     1'b1, 1'b0, 1'b1};
    vecs[12] = '{19'd77,     1'b0, 1'b0, 1'b0, 1'b0, 19'd13,     1'b1, 1'b0, 1'b1};
    vecs[13] = '{19'd5,      1'b0, 1'b0, 1'b0, 1'b0, 19'd5,      1'b1, 1'b0, 1'b1};
    vecs[14] = '{19'd50,     1'b0, 1'b1, 1'b0, 1'b0, 19'd50,     1'b0, 1'b0, 1'b1};

    // ---------------- reset with a write pending ----------------
    drive(1'b1, 19'd50, 1'b1, 1'b0);
    #1;
    check("reset_en1", en1, 1'b0);
    check("reset_en2", en2, 1'b0);
    step();
    step();
    check("reset_memSel", memSel, 1'b0);
    check("reset_decErr", decErr, 1'b0);
    check("reset_errSticky", errSticky, 1'b0);
    $display("txn reset: en1=%0b memSel=%0b decErr=%0b errSticky=%0b", en1, memSel, decErr, errSticky);

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, vecs[i].addr, vecs[i].wr, vecs[i].rd);
      #2;
      check($sformatf("v%0d_en1", i), en1, vecs[i].exp_en1);
      check($sformatf("v%0d_en2", i), en2, vecs[i].exp_en2);
      check($sformatf("v%0d_localAddr", i), localAddr, vecs[i].exp_la);
      check($sformatf("v%0d_en_exclusive", i), en1 & en2, 1'b0);
      step();
      check($sformatf("v%0d_memSel", i), memSel, vecs[i].exp_sel);
      check($sformatf("v%0d_decErr", i), decErr, vecs[i].exp_dec & DECERR_ON);
      check($sformatf("v%0d_errSticky", i), errSticky, vecs[i].exp_sticky & DECERR_ON);
      $display("txn v%0d: addr=0x%05h wr=%0b rd=%0b en1=%0b en2=%0b localAddr=0x%05h memSel=%0b decErr=%0b errSticky=%0b",
               i, vecs[i].addr, vecs[i].wr, vecs[i].rd, en1, en2, localAddr, memSel, decErr, errSticky);
    end

    // ---------------- reset arriving mid-access ----------------
    // Set up memSel=1 and a sticky error, then hit a write to mem1 with rst.
    drive(1'b0, 19'h20000, 1'b1, 1'b0);
    step();
    drive(1'b0, 19'd77, 1'b0, 1'b1);
    step();
    check("pre_rst_memSel", memSel, 1'b1);
    check("pre_rst_errSticky", errSticky, DECERR_ON);
    drive(1'b1, 19'd50, 1'b1, 1'b0);
    #2;
    check("mid_rst_en1", en1, 1'b0);
    check("mid_rst_en2", en2, 1'b0);
    step();
    check("post_rst_memSel", memSel, 1'b0);
    check("post_rst_decErr", decErr, 1'b0);
    check("post_rst_errSticky", errSticky, 1'b0);
    $display("txn mid_rst: en1=%0b memSel=%0b decErr=%0b errSticky=%0b", en1, memSel, decErr, errSticky);

    // Enables come back as soon as reset drops.
    drive(1'b0, 19'd50, 1'b1, 1'b0);
    #2;
    check("after_rst_en1", en1, 1'b1);
    step();
    check("after_rst_errSticky", errSticky, 1'b0);
    $display("txn after_rst: en1=%0b errSticky=%0b", en1, errSticky);

    drive(1'b0, 19'd0, 1'b0, 1'b0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_chip_set
